// File: rtl/updown_mod_counter_pkg.sv
// rtl/updown_mod_counter_pkg.sv - shared direction and boundary-mode constants
package updown_mod_counter_pkg;

   // Direction encoding for up_dn
   localparam logic DIR_UP = 1'b1;
   localparam logic DIR_DN = 1'b0;

   // Boundary behaviour encoding for sat_mode
   localparam logic MODE_WRAP = 1'b0;
   localparam logic MODE_SAT  = 1'b1;

endpackage

// File: rtl/updown_mod_counter_tick_prescaler.sv
// rtl/updown_mod_counter_tick_prescaler.sv - divides en-high cycles into one tick per PRESCALE
module tick_prescaler #(
   parameter int unsigned PRESCALE = 1
) (
   input  logic clk,
   input  logic rst_n,
   input  logic en,
   input  logic clr,
   output logic tick
);

   generate
      if (PRESCALE == 1) begin : g_wire
         // Every enabled cycle is a tick; no state is needed.
         logic unused_in;
         assign unused_in = ^{clk, rst_n, clr};
         assign tick      = en;
      end else begin : g_cnt
         localparam int unsigned CW = $clog2(PRESCALE);
         localparam logic [CW-1:0] LAST = CW'(PRESCALE - 1);

         logic [CW-1:0] cnt_q;
         logic [CW-1:0] cnt_d;

         // Advance on enabled cycles, restart after the last phase or on clear.
         always_comb begin
            cnt_d = cnt_q;
            if (clr) begin
               cnt_d = '0;
            end else if (en) begin
               cnt_d = (cnt_q == LAST) ? '0 : cnt_q + CW'(1);
            end
         end

         // Phase register; reset discards any partial period.
         always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
               cnt_q <= '0;
            end else begin
               cnt_q <= cnt_d;
            end
         end

         assign tick = en && (cnt_q == LAST);
      end
   endgenerate

endmodule

// File: rtl/updown_mod_counter.sv
// rtl/updown_mod_counter.sv - prescaled up/down modulo counter with wrap/saturate and overflow flag
module updown_mod_counter
   import updown_mod_counter_pkg::*;
#(
   parameter int unsigned WIDTH    = 8,
   parameter int unsigned MAX_VAL  = (2 ** WIDTH) - 1,
   parameter int unsigned PRESCALE = 1
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             en,
   input  logic             clr,
   input  logic             load,
   input  logic [WIDTH-1:0] load_val,
   input  logic             up_dn,
   input  logic             sat_mode,
   input  logic             ovf_clr,
   output logic [WIDTH-1:0] q,
   output logic             tc,
   output logic             ovf,
   output logic             at_max,
   output logic             at_min
);

   localparam logic [WIDTH-1:0] MAX_Q = WIDTH'(MAX_VAL);

   logic [WIDTH-1:0] q_q;
   logic [WIDTH-1:0] q_d;
   logic             tc_q;
   logic             tc_d;
   logic             ovf_q;
   logic             ovf_d;
   logic             tick;
   logic             pre_clr;

   // Load restarts the tick period just like clear does.
   assign pre_clr = clr || load;

   tick_prescaler #(
      .PRESCALE (PRESCALE)
   ) u_prescaler (
      .clk   (clk),
      .rst_n (rst_n),
      .en    (en),
      .clr   (pre_clr),
      .tick  (tick)
   );

   // Next count: clear beats load beats step; boundary steps raise tc.
   always_comb begin
      q_d  = q_q;
      tc_d = 1'b0;
      if (clr) begin
         q_d = '0;
      end else if (load) begin
         q_d = (load_val > MAX_Q) ? MAX_Q : load_val;
      end else if (tick) begin
         if (up_dn == DIR_UP) begin
            if (q_q >= MAX_Q) begin
               tc_d = 1'b1;
               q_d  = (sat_mode == MODE_SAT) ? MAX_Q : '0;
            end else begin
               q_d = q_q + WIDTH'(1);
            end
         end else begin
            if (q_q == '0) begin
               tc_d = 1'b1;
               q_d  = (sat_mode == MODE_SAT) ? '0 : MAX_Q;
            end else begin
               q_d = q_q - WIDTH'(1);
            end
         end
      end
      // A new boundary event wins over a simultaneous clear request.
      ovf_d = tc_d || (ovf_q && !ovf_clr);
   end

   // Count, pulse and sticky flag registers.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         q_q   <= '0;
         tc_q  <= 1'b0;
         ovf_q <= 1'b0;
      end else begin
         q_q   <= q_d;
         tc_q  <= tc_d;
         ovf_q <= ovf_d;
      end
   end

   assign q      = q_q;
   assign tc     = tc_q;
   assign ovf    = ovf_q;
   assign at_max = (q_q == MAX_Q);
   assign at_min = (q_q == '0);

endmodule

// File: tb/tb_updown_mod_counter.sv
// tb/tb_updown_mod_counter.sv - scoreboard bench for updown_mod_counter at PRESCALE 1 and 3
module tb_updown_mod_counter;

   localparam int MAXV = 9;

   typedef struct {
      logic [3:0] q;
      logic       tc;
      logic       ovf;
      logic       amax;
      logic       amin;
   } exp_t;

   logic       clk = 1'b0;
   logic       rst_n;
   logic       en;
   logic       clr;
   logic       load;
   logic [3:0] load_val;
   logic       up_dn;
   logic       sat_mode;
   logic       ovf_clr;

   logic [3:0] q_a, q_b;
   logic       tc_a, tc_b, ovf_a, ovf_b, amax_a, amax_b, amin_a, amin_b;

   int total = 0;
   int bad   = 0;

   exp_t sbq[$];

   int mq[2];
   int mpre[2];
   bit mtc[2];
   bit movf[2];

   always #5 clk = ~clk;

   updown_mod_counter #(.WIDTH(4), .MAX_VAL(9), .PRESCALE(1)) u_dut_a (
      .clk(clk), .rst_n(rst_n), .en(en), .clr(clr), .load(load),
      .load_val(load_val), .up_dn(up_dn), .sat_mode(sat_mode), .ovf_clr(ovf_clr),
      .q(q_a), .tc(tc_a), .ovf(ovf_a), .at_max(amax_a), .at_min(amin_a)
   );

   updown_mod_counter #(.WIDTH(4), .MAX_VAL(9), .PRESCALE(3)) u_dut_b (
      .clk(clk), .rst_n(rst_n), .en(en), .clr(clr), .load(load),
      .load_val(load_val), .up_dn(up_dn), .sat_mode(sat_mode), .ovf_clr(ovf_clr),
      .q(q_b), .tc(tc_b), .ovf(ovf_b), .at_max(amax_b), .at_min(amin_b)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   function automatic exp_t mk(input int i);
      exp_t e;
      e.q    = 4'(mq[i]);
      e.tc   = mtc[i];
      e.ovf  = movf[i];
      e.amax = (mq[i] == MAXV);
      e.amin = (mq[i] == 0);
      return e;
   endfunction

   task automatic model_reset();
      for (int i = 0; i < 2; i++) begin
         mq[i] = 0; mpre[i] = 0; mtc[i] = 0; movf[i] = 0;
      end
   endtask

   task automatic push_exp();
      sbq.push_back(mk(0));
      sbq.push_back(mk(1));
   endtask

   // Reference behaviour for one clock edge, both instances.
   task automatic model_step(input bit e, c, l, input int lv, input bit ud, sm, oc);
      int ps;
      bit tk;
      for (int i = 0; i < 2; i++) begin
         ps = (i == 0) ? 1 : 3;
         tk = e && (mpre[i] == ps - 1);
         mtc[i] = 0;
         if (c) begin
            mq[i] = 0; mpre[i] = 0;
         end else if (l) begin
            mq[i] = (lv > MAXV) ? MAXV : lv; mpre[i] = 0;
         end else begin
            if (e) mpre[i] = (mpre[i] == ps - 1) ? 0 : mpre[i] + 1;
            if (tk) begin
               if (ud) begin
                  if (mq[i] == MAXV) begin mtc[i] = 1; mq[i] = sm ? MAXV : 0; end
                  else mq[i] = mq[i] + 1;
               end else begin
                  if (mq[i] == 0) begin mtc[i] = 1; mq[i] = sm ? 0 : MAXV; end
                  else mq[i] = mq[i] - 1;
               end
            end
         end
         movf[i] = mtc[i] || (movf[i] && !oc);
      end
      push_exp();
   endtask

   task automatic check_all(input string tag);
      exp_t ea, eb;
      if (sbq.size() < 2) begin
         chk({tag, "_sb_empty"}, 32'(sbq.size()), 32'd2);
         return;
      end
      ea = sbq.pop_front();
      eb = sbq.pop_front();
      chk({tag, "_q_a"},    32'(q_a),    32'(ea.q));
      chk({tag, "_tc_a"},   32'(tc_a),   32'(ea.tc));
      chk({tag, "_ovf_a"},  32'(ovf_a),  32'(ea.ovf));
      chk({tag, "_amax_a"}, 32'(amax_a), 32'(ea.amax));
      chk({tag, "_amin_a"}, 32'(amin_a), 32'(ea.amin));
      chk({tag, "_q_b"},    32'(q_b),    32'(eb.q));
      chk({tag, "_tc_b"},   32'(tc_b),   32'(eb.tc));
      chk({tag, "_ovf_b"},  32'(ovf_b),  32'(eb.ovf));
      chk({tag, "_amax_b"}, 32'(amax_b), 32'(eb.amax));
      chk({tag, "_amin_b"}, 32'(amin_b), 32'(eb.amin));
   endtask

   task automatic cyc(input string tag, input bit e, c, l, input int lv, input bit ud, sm, oc);
      en = e; clr = c; load = l; load_val = 4'(lv);
      up_dn = ud; sat_mode = sm; ovf_clr = oc;
      model_step(e, c, l, lv, ud, sm, oc);
      @(posedge clk);
      #1;
      check_all(tag);
   endtask

   // Asynchronous reset pulse between edges, checked before any clock edge.
   task automatic mid_reset(input string tag);
      #3;
      rst_n = 1'b0;
      model_reset();
      push_exp();
      #1;
      check_all(tag);
      #2;
      rst_n = 1'b1;
   endtask

   initial begin
      rst_n = 1'b0; en = 0; clr = 0; load = 0; load_val = 0;
      up_dn = 1; sat_mode = 0; ovf_clr = 0;
      model_reset();
      repeat (2) @(posedge clk);
      #1;
      push_exp();
      check_all("reset");
      rst_n = 1'b1;

      // Wrap mode, counting up through the boundary.
      for (int i = 0; i < 12; i++) cyc("wrap_up", 1, 0, 0, 0, 1, 0, 0);
      chk("wrap_up_final_q", 32'(q_a), 32'd2);
      chk("wrap_up_final_ovf", 32'(ovf_a), 32'd1);

      // Clamped load and clear-over-load priority.
      cyc("load15", 0, 0, 1, 15, 1, 0, 0);
      chk("load15_q", 32'(q_a), 32'd9);
      cyc("load_clr", 0, 1, 1, 5, 1, 0, 0);
      chk("load_clr_q", 32'(q_a), 32'd0);

      // Saturating down steps.
      cyc("sat_load7", 0, 0, 1, 7, 0, 1, 1);
      for (int i = 0; i < 4; i++) cyc("sat_dn7", 1, 0, 0, 0, 0, 1, 0);
      cyc("sat_load1", 0, 0, 1, 1, 0, 1, 1);
      for (int i = 0; i < 3; i++) cyc("sat_dn1", 1, 0, 0, 0, 0, 1, 0);
      chk("sat_last_tc", 32'(tc_a), 32'd1);

      // ovf set and clear in the same cycle, then clear alone.
      cyc("ovf_pre_clr", 0, 0, 0, 0, 1, 0, 1);
      cyc("ovf_load9", 0, 0, 1, 9, 1, 0, 0);
      cyc("ovf_set_clr", 1, 0, 0, 0, 1, 0, 1);
      chk("ovf_set_clr_a", 32'(ovf_a), 32'd1);
      cyc("ovf_clr_only", 0, 0, 0, 0, 1, 0, 1);
      chk("ovf_clr_only_a", 32'(ovf_a), 32'd0);

      // Prescaler gating by en, with direction toggling between ticks.
      cyc("ps_clr", 0, 1, 0, 0, 1, 0, 0);
      cyc("ps_hi", 1, 0, 0, 0, 1, 0, 0);
      cyc("ps_hi", 1, 0, 0, 0, 1, 0, 0);
      for (int i = 0; i < 5; i++) cyc("ps_lo", 0, 0, 0, 0, i[0], 1, 0);
      chk("ps_before_q_b", 32'(q_b), 32'd0);
      cyc("ps_hi3", 1, 0, 0, 0, 1, 0, 0);
      chk("ps_after_q_b", 32'(q_b), 32'd1);

      // Asynchronous reset at q=5.
      cyc("rst_load5", 0, 0, 1, 5, 1, 0, 0);
      mid_reset("rst_mid");

      // Partial period discarded by reset.
      cyc("part_hi", 1, 0, 0, 0, 1, 0, 0);
      cyc("part_hi", 1, 0, 0, 0, 1, 0, 0);
      mid_reset("rst_part");
      for (int i = 0; i < 3; i++) cyc("part_full", 1, 0, 0, 0, 1, 0, 0);
      chk("part_full_q_b", 32'(q_b), 32'd1);

      // Mixed random traffic.
      for (int i = 0; i < 60; i++) begin
         cyc("rand",
             ($urandom_range(0, 3) != 0),
             ($urandom_range(0, 19) == 0),
             ($urandom_range(0, 9) == 0),
             int'($urandom_range(0, 15)),
             1'($urandom_range(0, 1)),
             1'($urandom_range(0, 1)),
             ($urandom_range(0, 4) == 0));
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin
      #100000;
      $display("FAIL timeout observed=running expected=finished");
      $fatal(1, "timeout");
   end

endmodule

// File: doc/updown_mod_counter.md
UPDOWN_MOD_COUNTER -- requirements
Module: updown_mod_counter

Interface
REQ-001 Parameter WIDTH, default 8: counter width in bits, legal range 2..32.
REQ-002 Parameter MAX_VAL, default 2**WIDTH-1: terminal value, count range 0..MAX_VAL, legal range 1..2**WIDTH-1.
REQ-003 Parameter PRESCALE, default 1: enabled cycles per count step, legal range 1..65535.
REQ-004 clk  input  1  sole clock; all state updates on its rising edge.
REQ-005 rst_n  input  1  reset; one clock; reset is asynchronous and active-low.
REQ-006 en  input  1  count enable; gates the prescaler and stepping.
REQ-007 clr  input  1  synchronous clear of count and prescaler.
REQ-008 load  input  1  synchronous load of load_val.
REQ-009 load_val  input  WIDTH  value for load.
REQ-010 up_dn  input  1  direction: 1 = up, 0 = down.
REQ-011 sat_mode  input  1  boundary mode: 1 = saturate, 0 = wrap.
REQ-012 ovf_clr  input  1  clears ovf.
REQ-013 q  output  WIDTH  registered count.
REQ-014 tc  output  1  registered one-cycle boundary-event pulse.
REQ-015 ovf  output  1  sticky boundary-event flag.
REQ-016 at_max  output  1  combinational, q == MAX_VAL.
REQ-017 at_min  output  1  combinational, q == 0.

Function
REQ-018 Priority per edge SHALL be clr > load > step; at most one of these SHALL take effect.
REQ-019 clr SHALL set q to 0 and the prescaler to 0 on the next edge; tc SHALL be 0 that cycle.
REQ-020 load SHALL set q to load_val if load_val <= MAX_VAL, else MAX_VAL; the prescaler SHALL reset to 0; tc SHALL be 0.
REQ-021 The prescaler SHALL count en-high cycles 0..PRESCALE-1 and SHALL produce an internal tick on the cycle it holds PRESCALE-1 with en high, then return to 0; with PRESCALE=1 tick SHALL equal en.
REQ-022 The prescaler SHALL hold its value while en is low.
REQ-023 A step SHALL occur on an edge where tick is 1 and neither clr nor load is asserted; q SHALL reflect the step one cycle after the tick cycle.
REQ-024 An up step with q < MAX_VAL SHALL give q+1; a down step with q > 0 SHALL give q-1.
REQ-025 An up step at MAX_VAL SHALL give 0 in wrap mode and hold MAX_VAL in saturate mode; a down step at 0 SHALL give MAX_VAL in wrap mode and hold 0 in saturate mode.
REQ-026 tc SHALL be 1 for exactly the cycle after each boundary step (REQ-025) and 0 otherwise, including repeated saturated steps.
REQ-027 ovf SHALL set on the edge tc is registered high and clear on ovf_clr; simultaneous set and clear SHALL leave ovf set.
REQ-028 up_dn and sat_mode SHALL be sampled only on tick cycles; changes between ticks SHALL have no effect.
REQ-029 All arithmetic SHALL be modulo range 0..MAX_VAL; q SHALL never exceed MAX_VAL.

Reset
REQ-030 rst_n low SHALL immediately force q=0, tc=0, ovf=0, and prescaler=0, independent of clk.
REQ-031 Deassertion of rst_n SHALL be synchronised by the integrator; the first step after release SHALL require a full PRESCALE tick period.
REQ-032 Reset asserted mid-period SHALL discard the partial prescaler count.

Structure
REQ-033 A shared package SHALL hold the direction constants (DIR_UP=1, DIR_DN=0) and mode constants (MODE_WRAP=0, MODE_SAT=1).
REQ-034 The prescaler SHALL be a sub-module named tick_prescaler with ports clk, rst_n, en, clr, and tick, where clr is driven by clr OR load.
REQ-035 When PRESCALE=1, tick_prescaler SHALL reduce to a wire with no registers.

Verification (WIDTH=4, MAX_VAL=9 unless stated)
REQ-036 PRESCALE=1, wrap, up, en=1 for 12 cycles from reset: q = 1..9, 0, 1, 2; tc high once, the cycle q shows 0; ovf=1 afterwards.
REQ-037 PRESCALE=1, saturate, load 7, then 4 down-steps ... load 1, then 3 down-steps: q = 0 then 0, 0; tc high on each of the last two cycles.
REQ-038 Load 15 (above MAX_VAL): q=9; load with clr in the same cycle: q=0.
REQ-039 PRESCALE=3, en toggled high 2 cycles, low 5 cycles, high 1 cycle: q steps 0->1 only after the third en-high cycle.
REQ-040 ovf_clr and tc-driven set in the same cycle: ovf stays 1; ovf_clr alone next cycle: ovf=0.
REQ-041 rst_n pulsed low between clock edges at q=5: q=0 and tc=0 immediately without a clk edge.
